// File: rtl/pipe_pkg.sv
// Shared EX->MEM pipeline definitions: control bit positions, default widths, slot payload.
package pipe_pkg;

    localparam int CTRL_WREG    = 0;
    localparam int CTRL_REG2REG = 1;
    localparam int CTRL_WMEM    = 2;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_W   = 5;
    localparam int DEF_CTRL_W = 3;
    localparam int DEF_CNT_W  = 16;

    typedef struct packed {
        logic [DEF_CTRL_W-1:0] ctrl;
        logic [DEF_DATA_W-1:0] alu_r;
        logic [DEF_DATA_W-1:0] d2;
        logic [DEF_RD_W-1:0]   rd;
    } ex_mem_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus payload register, synchronous clear beats load.
// Payload is zeroed whenever the slot is loaded empty, so idle slots carry a bubble.
module pipe_slot #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         clear,
    input  logic         load,
    input  logic         d_valid,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= d_valid;
            q     <= d_valid ? d : '0;
        end
    end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM stage with valid/ready handshake, optional 2-entry skid, flush, forwarding tap
// and saturating stall counter. One cycle accept-to-valid latency.
module ex_mem_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_W   = DEF_RD_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu_r,
    input  logic [DATA_W-1:0] in_d2,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu_r,
    output logic [DATA_W-1:0] out_d2,
    output logic [RD_W-1:0]   out_rd,
    output logic              fwd_en,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] alu_r;
        logic [DATA_W-1:0] d2;
        logic [RD_W-1:0]   rd;
    } slot_t;

    localparam int              SW  = $bits(slot_t);
    localparam logic [CNT_W-1:0] ONE = 1;

    slot_t in_pack;
    slot_t m_q;
    slot_t s_q;
    slot_t m_d;
    logic  m_valid, s_valid;
    logic  m_load, m_d_valid;
    logic  s_load, s_d_valid;
    logic  accept, fire;

    assign in_pack = {in_ctrl, in_alu_r, in_d2, in_rd};
    assign accept  = in_valid & in_ready;
    assign fire    = m_valid & out_ready;
    assign m_load  = ~m_valid | fire;

    pipe_slot #(.W(SW)) u_main (
        .clk     (clk),
        .clr     (clr),
        .clear   (flush),
        .load    (m_load),
        .d_valid (m_d_valid),
        .d       (m_d),
        .valid   (m_valid),
        .q       (m_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            // in_ready comes straight from the skid valid flop, so no path from out_ready.
            assign in_ready  = ~s_valid;
            assign m_d_valid = s_valid | accept;
            assign m_d       = s_valid ? s_q : in_pack;
            // When M advances, S drains into it and is emptied; otherwise S catches the input.
            assign s_load    = m_load ? s_valid : accept;
            assign s_d_valid = ~m_load & accept;

            pipe_slot #(.W(SW)) u_skid (
                .clk     (clk),
                .clr     (clr),
                .clear   (flush),
                .load    (s_load),
                .d_valid (s_d_valid),
                .d       (in_pack),
                .valid   (s_valid),
                .q       (s_q)
            );
        end else begin : g_noskid
            assign in_ready  = ~m_valid | out_ready;
            assign m_d_valid = accept;
            assign m_d       = in_pack;
            assign s_load    = 1'b0;
            assign s_d_valid = 1'b0;
            assign s_valid   = 1'b0;
            assign s_q       = '0;
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_q.ctrl : '0;
    assign out_alu_r = m_q.alu_r;
    assign out_d2    = m_q.d2;
    assign out_rd    = m_q.rd;

    assign fwd_en   = out_valid & out_ctrl[CTRL_WREG];
    assign fwd_rd   = out_rd;
    assign fwd_data = out_alu_r;

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + ONE;
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench: scoreboard on the skid instance plus directed checks on a SKID=0, CNT_W=4 instance.
module tb_ex_mem_skid_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_ctrl = '0;
    logic [31:0] in_alu_r = '0;
    logic [31:0] in_d2 = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_ctrl;
    logic [31:0] out_alu_r, out_d2, fwd_data;
    logic [4:0]  out_rd, fwd_rd;
    logic        fwd_en;
    logic [15:0] stall_cnt;

    logic        b_flush = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [2:0]  b_in_ctrl = '0;
    logic [31:0] b_in_alu_r = '0;
    logic [31:0] b_in_d2 = '0;
    logic [4:0]  b_in_rd = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [2:0]  b_out_ctrl;
    logic [31:0] b_out_alu_r, b_out_d2, b_fwd_data;
    logic [4:0]  b_out_rd, b_fwd_rd;
    logic        b_fwd_en;
    logic [3:0]  b_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    ex_mem_t sb[$];

    always #5 clk = ~clk;

    ex_mem_skid_stage #(.SKID(1)) dut (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_alu_r(in_alu_r), .in_d2(in_d2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_alu_r(out_alu_r), .out_d2(out_d2), .out_rd(out_rd),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt)
    );

    ex_mem_skid_stage #(.SKID(0), .CNT_W(4)) dut_b (
        .clk(clk), .clr(clr), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl),
        .in_alu_r(b_in_alu_r), .in_d2(b_in_d2), .in_rd(b_in_rd),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
        .out_alu_r(b_out_alu_r), .out_d2(b_out_d2), .out_rd(b_out_rd),
        .fwd_en(b_fwd_en), .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data),
        .stall_cnt(b_stall_cnt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs and accepts are sampled mid-cycle; the next rising edge commits them.
    always @(negedge clk) begin
        if (clr || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    check("sb_data", {out_ctrl, out_alu_r, out_d2, out_rd}, sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back({in_ctrl, in_alu_r, in_d2, in_rd});
        end
    end

    task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [4:0] r);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_alu_r = a;
        in_d2    = ~a;
        in_rd    = r;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_b_in_ready", b_in_ready, 1);
        clr = 1'b0;

        // async clear while an instruction sits in M
        @(posedge clk); #1;
        drive(3'b001, 32'hAB, 5'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("clr_pre_valid", out_valid, 1);
        #1 clr = 1'b1;
        #1;
        check("clr_out_valid", out_valid, 0);
        check("clr_out_ctrl", out_ctrl, 0);
        check("clr_out_alu_r", out_alu_r, 0);
        check("clr_stall_cnt", stall_cnt, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        #1;
        check("clr_in_ready", in_ready, 1);

        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(3'b001, 32'(i), 5'(i));
            @(posedge clk); #1;
            check("stream_valid", out_valid, 1);
            check("stream_alu_r", out_alu_r, i);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream_empty", out_valid, 0);
        check("stream_stall", stall_cnt, 0);

        // backpressure: A in M, B in skid
        out_ready = 1'b0;
        drive(3'b001, 32'h11, 5'd1);
        @(posedge clk); #1;
        drive(3'b001, 32'h22, 5'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_a", out_alu_r, 32'h11);
        repeat (2) @(posedge clk);
        #1;
        check("bp_still_a", out_alu_r, 32'h11);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_b", out_alu_r, 32'h22);
        check("bp_ready_back", in_ready, 1);
        @(posedge clk); #1;
        check("bp_drained", out_valid, 0);

        // flush with both slots full and a pending input
        out_ready = 1'b0;
        drive(3'b101, 32'h33, 5'd4);
        @(posedge clk); #1;
        drive(3'b101, 32'h44, 5'd5);
        @(posedge clk); #1;
        drive(3'b101, 32'h55, 5'd6);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_out_ctrl", out_ctrl, 0);
        check("fl_alu_r", out_alu_r, 0);
        check("fl_in_ready", in_ready, 1);
        drive(3'b101, 32'h66, 5'd7);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_drop_accept", out_valid, 0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // forwarding tap
        out_ready = 1'b0;
        drive(3'b001, 32'hDEAD, 5'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("fwd_en_on", fwd_en, 1);
        check("fwd_rd", fwd_rd, 7);
        check("fwd_data", fwd_data, 32'hDEAD);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(3'b000, 32'hDEAD, 5'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("fwd_en_off", fwd_en, 0);
        check("fwd_off_valid", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // saturating stall counter on the SKID=0 instance
        b_in_valid = 1'b1;
        b_in_ctrl  = 3'b001;
        b_in_alu_r = 32'h77;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        check("b_in_ready_stall", b_in_ready, 0);
        check("b_out_alu_r", b_out_alu_r, 32'h77);
        repeat (4) @(posedge clk);
        #1;
        check("b_stall_4", b_stall_cnt, 4);
        repeat (16) @(posedge clk);
        #1;
        check("b_stall_sat", b_stall_cnt, 15);
        b_out_ready = 1'b1;
        #1;
        check("b_in_ready_comb", b_in_ready, 1);
        b_out_ready = 1'b0;
        b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        check("b_flush_cnt", b_stall_cnt, 15);
        check("b_flush_valid", b_out_valid, 0);
        check("b_flush_ready", b_in_ready, 1);

        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
